// File: rtl/iir_biquad_cascade_pkg.sv
// Shared types and arithmetic helpers for the biquad cascade.
package iir_pkg;
    localparam int K_B0 = 0;
    localparam int K_B1 = 1;
    localparam int K_B2 = 2;
    localparam int K_A1 = 3;
    localparam int K_A2 = 4;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC, S_WB, S_DONE} state_t;

    typedef struct packed {
        logic              ovf;
        logic signed [63:0] val;
    } sat_t;

    // Five Q1 x Q2 products plus headroom: the accumulator can never wrap.
    function automatic int accw(input int dw, input int cw);
        return dw + cw + 3;
    endfunction

    function automatic sat_t sat_round(input logic signed [63:0] acc, input int shift,
                                       input int dw, input logic sat);
        sat_t r;
        logic signed [63:0] rnd;
        logic signed [63:0] vmax;
        logic signed [63:0] vmin;
        rnd   = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        vmax  = (64'sd1 <<< (dw - 1)) - 64'sd1;
        vmin  = -(64'sd1 <<< (dw - 1));
        r.ovf = (rnd > vmax) || (rnd < vmin);
        r.val = rnd;
        if (sat && (rnd > vmax)) r.val = vmax;
        if (sat && (rnd < vmin)) r.val = vmin;
        return r;
    endfunction
endpackage

// File: rtl/iir_biquad_cascade_if.sv
// Sample stream, coefficient configuration and status bundle of the biquad cascade.
interface iir_biquad_cascade_if #(
    parameter int DW = 16,
    parameter int CW = 16
);
    logic signed [DW-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_valid;
    logic                 cfg_we;
    logic [5:0]           cfg_addr;
    logic signed [CW-1:0] cfg_wdata;
    logic                 cfg_commit;
    logic                 clear;
    logic                 ovf;

    modport master (
        output in_data, in_valid, cfg_we, cfg_addr, cfg_wdata, cfg_commit, clear,
        input  in_ready, out_data, out_valid, ovf
    );
    modport slave (
        input  in_data, in_valid, cfg_we, cfg_addr, cfg_wdata, cfg_commit, clear,
        output in_ready, out_data, out_valid, ovf
    );
endinterface

// File: rtl/iir_biquad_cascade_coef_bank.sv
// Shadow/active coefficient banks; a commit copies shadow including a same-cycle write.
module iir_coef_bank
    import iir_pkg::*;
#(
    parameter int N_SECT = 2,
    parameter int CW     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_we,
    input  logic [5:0]           i_addr,
    input  logic signed [CW-1:0] i_wdata,
    input  logic                 i_commit,
    input  logic [2:0]           i_sect,
    input  logic [2:0]           i_k,
    output logic signed [CW-1:0] o_coef
);
    localparam int NCOEF = 5 * N_SECT;

    logic signed [CW-1:0] r_shadow     [NCOEF];
    logic signed [CW-1:0] r_active     [NCOEF];
    logic signed [CW-1:0] w_shadow_nxt [NCOEF];
    logic [5:0]           w_idx;

    assign w_idx = 6'(i_sect) * 6'd5 + 6'(i_k);

    always_comb begin
        w_shadow_nxt = r_shadow;
        for (int i = 0; i < NCOEF; i++) begin
            if (i_we && (i_addr == 6'(i))) w_shadow_nxt[i] = i_wdata;
        end
    end

    always_comb begin
        o_coef = '0;
        for (int i = 0; i < NCOEF; i++) begin
            if (w_idx == 6'(i)) o_coef = r_active[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCOEF; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_shadow <= w_shadow_nxt;
            if (i_commit) r_active <= w_shadow_nxt;
        end
    end
endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of N_SECT Direct-Form-I biquads sharing one MAC: 5 MAC cycles + 1 writeback per section.
//  state  | meaning
//  S_IDLE | ready for a sample; pending commit/clear applied here
//  S_MAC  | accumulate term r_k of section r_sect
//  S_WB   | round/limit, shift taps, pass y0 on as next section input
//  S_DONE | register last section output, pulse out_valid
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int N_SECT = 2,
    parameter int DW     = 16,
    parameter int CW     = 16,
    parameter int SAT    = 1
) (
    input logic                 clk,
    input logic                 reset_n,
    iir_biquad_cascade_if.slave bus
);
    localparam int         ACCW  = accw(DW, CW);
    localparam int         SHIFT = CW - 2;
    localparam logic [2:0] LAST  = 3'(N_SECT - 1);

    state_t                 r_state, w_state_nxt;
    logic [2:0]             r_sect, r_k;
    logic signed [ACCW-1:0] r_acc;
    logic signed [DW-1:0]   r_x0;
    logic signed [DW-1:0]   r_x1 [N_SECT];
    logic signed [DW-1:0]   r_x2 [N_SECT];
    logic signed [DW-1:0]   r_y1 [N_SECT];
    logic signed [DW-1:0]   r_y2 [N_SECT];
    logic signed [DW-1:0]   r_out_data;
    logic                   r_out_valid, r_ovf, r_commit_pend, r_clear_pend;

    logic                    w_idle, w_commit, w_clear;
    logic signed [CW-1:0]    w_coef;
    logic signed [DW-1:0]    w_x1, w_x2, w_y1, w_y2, w_tap, w_y0;
    logic signed [DW+CW-1:0] w_prod;
    logic signed [ACCW-1:0]  w_term;
    sat_t                    w_sr;

    assign w_idle   = (r_state == S_IDLE);
    assign w_commit = w_idle & (r_commit_pend | bus.cfg_commit);
    assign w_clear  = w_idle & (r_clear_pend | bus.clear);

    iir_coef_bank #(.N_SECT(N_SECT), .CW(CW)) u_bank (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_we     (bus.cfg_we),
        .i_addr   (bus.cfg_addr),
        .i_wdata  (bus.cfg_wdata),
        .i_commit (w_commit),
        .i_sect   (r_sect),
        .i_k      (r_k),
        .o_coef   (w_coef)
    );

    always_comb begin
        w_x1 = '0;
        w_x2 = '0;
        w_y1 = '0;
        w_y2 = '0;
        for (int s = 0; s < N_SECT; s++) begin
            if (r_sect == 3'(s)) begin
                w_x1 = r_x1[s];
                w_x2 = r_x2[s];
                w_y1 = r_y1[s];
                w_y2 = r_y2[s];
            end
        end
        case (r_k)
            3'(K_B1): w_tap = w_x1;
            3'(K_B2): w_tap = w_x2;
            3'(K_A1): w_tap = w_y1;
            3'(K_A2): w_tap = w_y2;
            default:  w_tap = r_x0;
        endcase
    end

    // Feedback terms enter negated so stored a1/a2 keep their textbook sign.
    assign w_prod = (DW+CW)'(w_coef) * (DW+CW)'(w_tap);
    assign w_term = (r_k >= 3'(K_A1)) ? -ACCW'(w_prod) : ACCW'(w_prod);
    assign w_sr   = sat_round(64'(r_acc), SHIFT, DW, (SAT != 0));
    assign w_y0   = DW'(w_sr.val);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_state_nxt = S_MAC;
            S_MAC:   if (r_k == 3'(K_A2)) w_state_nxt = S_WB;
            S_WB:    w_state_nxt = (r_sect == LAST) ? S_DONE : S_MAC;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sect        <= '0;
            r_k           <= '0;
            r_acc         <= '0;
            r_x0          <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_ovf         <= 1'b0;
            r_commit_pend <= 1'b0;
            r_clear_pend  <= 1'b0;
            for (int s = 0; s < N_SECT; s++) begin
                r_x1[s] <= '0;
                r_x2[s] <= '0;
                r_y1[s] <= '0;
                r_y2[s] <= '0;
            end
        end else begin
            r_out_valid   <= 1'b0;
            r_commit_pend <= w_commit ? 1'b0 : (r_commit_pend | bus.cfg_commit);
            r_clear_pend  <= w_clear  ? 1'b0 : (r_clear_pend | bus.clear);
            if (w_clear) begin
                r_ovf <= 1'b0;
                for (int s = 0; s < N_SECT; s++) begin
                    r_x1[s] <= '0;
                    r_x2[s] <= '0;
                    r_y1[s] <= '0;
                    r_y2[s] <= '0;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_x0   <= bus.in_data;
                        r_acc  <= '0;
                        r_sect <= '0;
                        r_k    <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_term;
                    r_k   <= r_k + 3'd1;
                end
                S_WB: begin
                    for (int s = 0; s < N_SECT; s++) begin
                        if (r_sect == 3'(s)) begin
                            r_x2[s] <= r_x1[s];
                            r_x1[s] <= r_x0;
                            r_y2[s] <= r_y1[s];
                            r_y1[s] <= w_y0;
                        end
                    end
                    r_x0  <= w_y0;
                    r_acc <= '0;
                    r_k   <= '0;
                    if (w_sr.ovf) r_ovf <= 1'b1;
                    if (r_sect != LAST) r_sect <= r_sect + 3'd1;
                end
                S_DONE: begin
                    r_out_data  <= r_y1[N_SECT-1];
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.ovf       = r_ovf;
endmodule
